imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the 11-bit instruction memory. The memory's read port is driven by PC.
//  Accepts a nibble stream over a valid/ready handshake, assembles 11-bit instructions and
//  writes them into the writable instruction RAM from address 0 upward.
//  Holds the processor in reset (cpu_hold) until a complete, well-formed program is loaded.
// PARAMETERS
//  DEPTH   128  instruction RAM depth in words; count above DEPTH is an error
//  AW      8    address width; matches PC width
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  load_start in   1   1-cycle pulse: begin or restart a load
//  in_data    in   4   stream nibble
//  in_valid   in   1   in_data valid
//  in_ready   out  1   loader accepts nibble; transfer = in_valid & in_ready
//  wr_en      out  1   instruction RAM write strobe
//  wr_addr    out  AW  write address
//  wr_data    out  11  instruction word
//  cpu_hold   out  1   1 = keep processor in reset
//  done       out  1   program loaded; held until next load_start
//  error      out  1   malformed stream; held until next load_start
// BEHAVIOUR
//  Reset (async, reset=0) forces:
//   - state=IDLE
//   - in_ready=0, wr_en=0, wr_addr=0, wr_data=0
//   - cpu_hold=1, done=0, error=0
//  Frame format: CNT_HI, CNT_LO (8-bit count N), then N instructions of 3 nibbles each.
//   - Instruction nibbles arrive MS first: {n2[2:0], n1, n0}. n2[3] must be 0.
//  State transitions:
//   - IDLE -> CNT_HI on load_start. Sets cpu_hold=1, done=0, error=0, wr_addr=0.
//   - CNT_HI -> CNT_LO on transfer.
//   - CNT_LO on transfer: N==0 -> DONE; N>DEPTH -> ERR; otherwise -> NIB2.
//   - NIB2 -> NIB1 on transfer; if n2[3]==1 -> ERR instead.
//   - NIB1 -> NIB0 on transfer.
//   - NIB0 -> WRITE on transfer.
//   - WRITE (exactly 1 cycle): wr_en=1, wr_data=assembled word.
//     If wr_addr==N-1 -> DONE; otherwise wr_addr+1 and -> NIB2.
//   - DONE: done=1, cpu_hold=0. Stays until load_start.
//   - ERR: error=1, cpu_hold=1. Stays until load_start.
//  in_ready:
//   - Registered; 1 only in CNT_HI, CNT_LO, NIB2, NIB1, NIB0.
//   - 0 in IDLE, WRITE, DONE, ERR.
//  Throughput: at most 1 nibble/cycle; 4 cycles minimum per instruction (3 nibbles + WRITE).
//  Any stall length on in_valid is allowed; state holds and no data is lost.
//  load_start in any state, mid-load included:
//   - Aborts the current load and goes to CNT_HI the next cycle.
//   - Takes priority over a same-cycle transfer; that nibble is dropped.
//   - Takes priority over a same-cycle WRITE; wr_en is forced 0 that cycle.
//  wr_data/wr_addr: stable only while wr_en=1. Address never exceeds DEPTH-1; no wrap-around.
//  N==DEPTH is legal and fills the whole memory.
//  Asserting reset mid-load returns to IDLE with cpu_hold=1. RAM contents are not cleared.
// TESTING
//  T1 reset low then high -> in_ready=0, cpu_hold=1, done=0, error=0, wr_en=0
//  T2 load_start; stream 0,2, 0,A,5, 7,F,F -> two writes:
//     wr_addr0=0x0A5, wr_addr1=0x7FF; then done=1, cpu_hold=0
//  T3 load_start; count 0x00 -> done=1 with no wr_en pulse
//  T4 count 0x81 (129 > DEPTH) -> error=1, cpu_hold=1, no writes;
//     then n2=0x8 in a fresh load -> error=1
//  T5 stall in_valid 5 cycles between nibbles of T2 stream -> identical writes, identical data
//  T6 load_start after 1st write of a 3-word load -> restart at addr 0; full new program
//     written, done=1

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader -- writer side of the 11-bit instruction memory.
//
// Accepts a nibble stream over a valid/ready handshake, assembles 11-bit
// instructions and writes them into the instruction RAM from address 0 upward.
// The processor is held in reset (cpu_hold_o) until a complete, well-formed
// program has been loaded.
//
// Frame: CNT_HI, CNT_LO (8-bit count N), then N instructions of three nibbles,
// most significant first: {n2[2:0], n1, n0}. n2[3] must be 0.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   load_start_i  1-cycle pulse: begin or restart a load (aborts any load in progress)
//   in_data_i     stream nibble
//   in_valid_i    in_data_i valid
//   in_ready_o    loader accepts a nibble; transfer = in_valid_i & in_ready_o
//   wr_en_o       instruction RAM write strobe
//   wr_addr_o     write address
//   wr_data_o     instruction word
//   cpu_hold_o    1 = keep processor in reset
//   done_o        program loaded; held until next load_start_i
//   error_o       malformed stream; held until next load_start_i
//
// state  | meaning
// IDLE   | after reset, waiting for load_start_i
// CNT_HI | waiting for count high nibble
// CNT_LO | waiting for count low nibble
// NIB2   | waiting for instruction bits [10:8] (bit 3 must be 0)
// NIB1   | waiting for instruction bits [7:4]
// NIB0   | waiting for instruction bits [3:0]
// WRITE  | one-cycle RAM write of the assembled word
// DONE   | program loaded, processor released
// ERR    | malformed stream, processor held
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_start_i,
    input  logic [3:0]    in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [10:0]   wr_data_o,
    output logic          cpu_hold_o,
    output logic          done_o,
    output logic          error_o
);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, NIB2, NIB1, NIB0, WRITE, DONE, ERR
    } state_e;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [10:0]   word_q, word_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en;
    logic          transfer;
    logic [7:0]    n_cnt;
    logic [AW-1:0] last_addr;

    assign transfer  = in_valid_i & in_ready_q;
    assign n_cnt     = {cnt_q[7:4], in_data_i};
    assign last_addr = AW'(cnt_q - 8'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        // load_start wins over any same-cycle transfer or write.
        if (load_start_i) begin
            state_d = CNT_HI;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                CNT_HI: if (transfer) begin
                    cnt_d[7:4] = in_data_i;
                    state_d    = CNT_LO;
                end
                CNT_LO: if (transfer) begin
                    cnt_d = n_cnt;
                    if (n_cnt == 8'd0)               state_d = DONE;
                    else if ({1'b0, n_cnt} > DEPTH_W) state_d = ERR;
                    else                              state_d = NIB2;
                end
                NIB2: if (transfer) begin
                    if (in_data_i[3]) begin
                        state_d = ERR;
                    end else begin
                        word_d[10:8] = in_data_i[2:0];
                        state_d      = NIB1;
                    end
                end
                NIB1: if (transfer) begin
                    word_d[7:4] = in_data_i;
                    state_d     = NIB0;
                end
                NIB0: if (transfer) begin
                    word_d[3:0] = in_data_i;
                    state_d     = WRITE;
                end
                WRITE: begin
                    wr_en = 1'b1;
                    if (addr_q == last_addr) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = NIB2;
                    end
                end
                DONE: ;
                ERR: ;
                default: state_d = IDLE;
            endcase
        end
        // Registered ready follows the state being entered.
        in_ready_d = (state_d == CNT_HI) || (state_d == CNT_LO) ||
                     (state_d == NIB2)   || (state_d == NIB1)   || (state_d == NIB0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign wr_en_o    = wr_en;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = word_q;
    assign cpu_hold_o = (state_q != DONE);
    assign done_o     = (state_q == DONE);
    assign error_o    = (state_q == ERR);

endmodule
